// File: rtl/pe_btf_if.sv
// Handshake and data bundle for the radix-2 butterfly pipeline.
// The master side is the producer/consumer environment; the slave side is the butterfly.
interface pe_btf_if #(
   parameter int DW = 8,
   parameter int TW = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in0_re;
   logic signed [DW-1:0] in0_im;
   logic signed [DW-1:0] in1_re;
   logic signed [DW-1:0] in1_im;
   logic signed [TW-1:0] tw_re;
   logic signed [TW-1:0] tw_im;
   logic                 inv;
   logic                 scale;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out0_re;
   logic signed [DW-1:0] out0_im;
   logic signed [DW-1:0] out1_re;
   logic signed [DW-1:0] out1_im;
   logic                 ovf;

   modport master (
      output in_valid, in0_re, in0_im, in1_re, in1_im, tw_re, tw_im, inv, scale, out_ready,
      input  in_ready, out_valid, out0_re, out0_im, out1_re, out1_im, ovf
   );

   modport slave (
      input  in_valid, in0_re, in0_im, in1_re, in1_im, tw_re, tw_im, inv, scale, out_ready,
      output in_ready, out_valid, out0_re, out0_im, out1_re, out1_im, ovf
   );
endinterface

// File: rtl/pe_btf_pipe.sv
// Three-stage radix-2 DIF butterfly: out0 = a+b, out1 = (a-b)*tw, with optional conj/scale.
// Define PE_BTF_SAT_EN to saturate out-of-range results and report ovf; otherwise results wrap.
module pe_btf_pipe #(
   parameter int DW = 8,
   parameter int TW = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   pe_btf_if.slave   bus
);
   localparam int FRAC = TW - 1;
   localparam int AW   = DW + 1;
   localparam int PW   = AW + TW;
   localparam int XW   = PW + 2;
   localparam logic signed [TW-1:0] TW_MIN = {1'b1, {(TW-1){1'b0}}};
   localparam logic signed [TW-1:0] TW_MAX = ~TW_MIN;
`ifdef PE_BTF_SAT_EN
   localparam logic signed [XW-1:0] LIM_HI = XW'(2**(DW-1) - 1);
   localparam logic signed [XW-1:0] LIM_LO = ~LIM_HI;
`endif

   logic en;

   logic                 s1_v, s1_inv, s1_scale;
   logic signed [AW-1:0] s1_sum_re, s1_sum_im, s1_d_re, s1_d_im;
   logic signed [TW-1:0] s1_tw_re, s1_tw_im;

   logic                 s2_v, s2_scale;
   logic signed [AW-1:0] s2_sum_re, s2_sum_im;
   logic signed [PW-1:0] s2_p_rr, s2_p_ii, s2_p_ri, s2_p_ir;

   logic                 s3_v, s3_ovf;
   logic signed [DW-1:0] s3_out0_re, s3_out0_im, s3_out1_re, s3_out1_im;

   logic signed [TW-1:0] tw_im_c;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [XW-1:0] acc_re, acc_im, rnd, sc_add;
   logic signed [XW-1:0] r0_re, r0_im, r1_re, r1_im;
   logic [DW:0]          n0_re, n0_im, n1_re, n1_im;

   // Whole pipe moves as one; a stalled S3 freezes everything behind it.
   assign en           = !s3_v || bus.out_ready;
   assign bus.in_ready = en;

   function automatic logic [DW:0] narrow(input logic signed [XW-1:0] x);
`ifdef PE_BTF_SAT_EN
      if (x > LIM_HI)      return {1'b1, LIM_HI[DW-1:0]};
      else if (x < LIM_LO) return {1'b1, LIM_LO[DW-1:0]};
      else                 return {1'b0, x[DW-1:0]};
`else
      return {1'b0, x[DW-1:0]};
`endif
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_inv    <= 1'b0;
         s1_scale  <= 1'b0;
         s1_sum_re <= '0;
         s1_sum_im <= '0;
         s1_d_re   <= '0;
         s1_d_im   <= '0;
         s1_tw_re  <= '0;
         s1_tw_im  <= '0;
      end else if (en) begin
         s1_v      <= bus.in_valid;
         s1_inv    <= bus.inv;
         s1_scale  <= bus.scale;
         s1_sum_re <= {bus.in0_re[DW-1], bus.in0_re} + {bus.in1_re[DW-1], bus.in1_re};
         s1_sum_im <= {bus.in0_im[DW-1], bus.in0_im} + {bus.in1_im[DW-1], bus.in1_im};
         s1_d_re   <= {bus.in0_re[DW-1], bus.in0_re} - {bus.in1_re[DW-1], bus.in1_re};
         s1_d_im   <= {bus.in0_im[DW-1], bus.in0_im} - {bus.in1_im[DW-1], bus.in1_im};
         s1_tw_re  <= bus.tw_re;
         s1_tw_im  <= bus.tw_im;
      end
   end

   // Conjugation must not wrap the most negative twiddle back onto itself.
   always_comb begin
      tw_im_c = s1_tw_im;
      if (s1_inv) tw_im_c = (s1_tw_im == TW_MIN) ? TW_MAX : -s1_tw_im;
   end

   assign p_rr = PW'(s1_d_re) * PW'(s1_tw_re);
   assign p_ii = PW'(s1_d_im) * PW'(tw_im_c);
   assign p_ri = PW'(s1_d_re) * PW'(tw_im_c);
   assign p_ir = PW'(s1_d_im) * PW'(s1_tw_re);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v      <= 1'b0;
         s2_scale  <= 1'b0;
         s2_sum_re <= '0;
         s2_sum_im <= '0;
         s2_p_rr   <= '0;
         s2_p_ii   <= '0;
         s2_p_ri   <= '0;
         s2_p_ir   <= '0;
      end else if (en) begin
         s2_v      <= s1_v;
         s2_scale  <= s1_scale;
         s2_sum_re <= s1_sum_re;
         s2_sum_im <= s1_sum_im;
         s2_p_rr   <= p_rr;
         s2_p_ii   <= p_ii;
         s2_p_ri   <= p_ri;
         s2_p_ir   <= p_ir;
      end
   end

   always_comb begin
      acc_re = XW'(s2_p_rr) - XW'(s2_p_ii);
      acc_im = XW'(s2_p_ri) + XW'(s2_p_ir);
      rnd    = '0;
      if (s2_scale) rnd[FRAC]   = 1'b1;
      else          rnd[FRAC-1] = 1'b1;
      sc_add    = '0;
      sc_add[0] = s2_scale;
      r1_re  = (acc_re + rnd) >>> (s2_scale ? FRAC + 1 : FRAC);
      r1_im  = (acc_im + rnd) >>> (s2_scale ? FRAC + 1 : FRAC);
      r0_re  = (XW'(s2_sum_re) + sc_add) >>> s2_scale;
      r0_im  = (XW'(s2_sum_im) + sc_add) >>> s2_scale;
      n0_re  = narrow(r0_re);
      n0_im  = narrow(r0_im);
      n1_re  = narrow(r1_re);
      n1_im  = narrow(r1_im);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_v       <= 1'b0;
         s3_ovf     <= 1'b0;
         s3_out0_re <= '0;
         s3_out0_im <= '0;
         s3_out1_re <= '0;
         s3_out1_im <= '0;
      end else if (en) begin
         s3_v       <= s2_v;
         s3_ovf     <= s2_v & (n0_re[DW] | n0_im[DW] | n1_re[DW] | n1_im[DW]);
         s3_out0_re <= n0_re[DW-1:0];
         s3_out0_im <= n0_im[DW-1:0];
         s3_out1_re <= n1_re[DW-1:0];
         s3_out1_im <= n1_im[DW-1:0];
      end
   end

   assign bus.out_valid = s3_v;
   assign bus.ovf       = s3_ovf;
   assign bus.out0_re   = s3_out0_re;
   assign bus.out0_im   = s3_out0_im;
   assign bus.out1_re   = s3_out1_re;
   assign bus.out1_im   = s3_out1_im;
endmodule

// File: doc/pe_btf_pipe.md
PE_BTF_PIPE -- requirements
Module: pe_btf_pipe

Interface
REQ-001 SHALL have parameter DW, default 8: signed data width of all data inputs and outputs.
REQ-002 SHALL have parameter TW, default 8: signed twiddle width, Q1.(TW-1) format, FRAC = TW-1.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port in0_re  input  DW  operand A real, signed.
REQ-008 SHALL have port in0_im  input  DW  operand A imaginary, signed.
REQ-009 SHALL have port in1_re  input  DW  operand B real, signed.
REQ-010 SHALL have port in1_im  input  DW  operand B imaginary, signed.
REQ-011 SHALL have port tw_re  input  TW  twiddle real, signed.
REQ-012 SHALL have port tw_im  input  TW  twiddle imaginary, signed.
REQ-013 SHALL have port inv  input  1  per-beat inverse mode: conjugate twiddle.
REQ-014 SHALL have port scale  input  1  per-beat divide-by-2 of both outputs.
REQ-015 SHALL have port out_valid  output  1  output beat valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-017 SHALL have port out0_re  output  DW  sum real.
REQ-018 SHALL have port out0_im  output  DW  sum imaginary.
REQ-019 SHALL have port out1_re  output  DW  twiddled difference real.
REQ-020 SHALL have port out1_im  output  DW  twiddled difference imaginary.
REQ-021 SHALL have port ovf  output  1  overflow on current output beat, qualified by out_valid.

Function
REQ-022 SHALL be a 3-stage pipeline: S1 registers sum/difference (DW+1 bits) plus inv/scale; S2 registers four products at full width; S3 registers rounded, scaled, narrowed results.
REQ-023 SHALL advance all stages together when en = !out_valid || out_ready; in_ready = en (combinational); a beat is accepted when in_valid && in_ready.
REQ-024 SHALL propagate a valid bit per stage; bubbles SHALL NOT be collapsed; latency exactly 3 enabled cycles.
REQ-025 SHALL hold S3 outputs and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL compute d = in0 - in1 and out1 = d * tw, with tw_im negated when inv=1 (negating -2^(TW-1) saturates to 2^(TW-1)-1).
REQ-027 SHALL compute out1 as (product_sum + 2^(S-1)) >>> S, S = FRAC + scale (round half up, arithmetic shift).
REQ-028 SHALL compute out0 as (in0 + in1 + scale) >>> scale.
REQ-029 SHALL treat all arithmetic as signed two's complement with no intermediate truncation before the final narrowing to DW.
REQ-030 SHALL assert ovf when any of the four pre-narrowing results falls outside [-2^(DW-1), 2^(DW-1)-1].

Reset
REQ-031 SHALL on rst_n low immediately clear all stage valids, out_valid, ovf and all data outputs to 0, discarding in-flight beats.
REQ-032 SHALL drive in_ready = 1 during and after reset (out_valid = 0).

Configuration
REQ-033 SHALL with PE_BTF_SAT_EN defined clamp each out-of-range result to the nearest limit and report ovf.
REQ-034 SHALL without PE_BTF_SAT_EN wrap (keep low DW bits) and tie ovf to 0.

Verification (DW=8, TW=8)
REQ-035 in0=(10,20), in1=(3,4), tw=(127,0), inv=0, scale=0, out_ready=1 -> 3 cycles later out0=(13,24), out1=(7,16), ovf=0.
REQ-036 in0=(10,20), in1=(3,4), tw=(0,127): inv=0 -> out1=(-16,7); inv=1 -> out1=(16,-7).
REQ-037 in0=(100,0), in1=(100,0), scale=0 -> SAT_EN: out0_re=127, ovf=1; no SAT_EN: out0_re=-56, ovf=0; scale=1 -> out0_re=100, ovf=0 both builds.
REQ-038 out_ready=0, in_valid=1 for 5 cycles -> exactly 3 beats accepted, in_ready=0 afterwards, outputs stable; out_ready=1 -> 3 beats emitted in order, then in_ready=1.
REQ-039 rst_n low while out_valid=1 with 2 beats in flight -> out_valid=0 and outputs 0 immediately; after release no stale beat appears.
